// File: rtl/mac_dot_seq.sv
// Sequencer/accumulator wrapped around the 4-lane mac_wrapper: stages one chunk per
// cycle onto the lane operands, feeds the running sum back and emits one result per vector.
module mac_dot_seq #(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned len_bw  = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [4*bw-1:0]      i_x_in,
  input  logic [4*bw-1:0]      i_w_in,
  input  logic                 i_in_last,
  output logic [bw-1:0]        o_x0,
  output logic [bw-1:0]        o_x1,
  output logic [bw-1:0]        o_x2,
  output logic [bw-1:0]        o_x3,
  output logic [bw-1:0]        o_w0,
  output logic [bw-1:0]        o_w1,
  output logic [bw-1:0]        o_w2,
  output logic [bw-1:0]        o_w3,
  output logic [psum_bw-1:0]   o_psum_in,
  input  logic [psum_bw-1:0]   i_mac_out,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [psum_bw-1:0]   o_out_data,
  output logic [len_bw-1:0]    o_out_count
);

  logic                r_s_valid;
  logic                r_s_last;
  logic [4*bw-1:0]     r_x;
  logic [4*bw-1:0]     r_w;
  logic [psum_bw-1:0]  r_acc;
  logic [len_bw-1:0]   r_cnt;
  logic                r_out_valid;
  logic [psum_bw-1:0]  r_out_data;
  logic [len_bw-1:0]   r_out_count;

  logic w_stall;
  logic w_accept;
  logic w_commit;
  logic w_commit_last;

  // Only a staged last chunk with an unconsumed result blocks progress.
  assign w_stall       = r_s_valid & r_s_last & r_out_valid & ~i_out_ready;
  assign w_accept      = i_in_valid & ~w_stall;
  assign w_commit      = r_s_valid & ~w_stall;
  assign w_commit_last = w_commit & r_s_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s_valid   <= 1'b0;
      r_s_last    <= 1'b0;
      r_x         <= '0;
      r_w         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_commit) begin
        if (r_s_last) begin
          r_out_data  <= i_mac_out;
          r_out_count <= r_cnt + 1'b1;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= i_mac_out;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (!w_stall) begin
        if (w_accept) begin
          r_s_valid <= 1'b1;
          r_s_last  <= i_in_last;
          r_x       <= i_x_in;
          r_w       <= i_w_in;
        end else begin
          r_s_valid <= 1'b0;
        end
      end
    end
  end

  assign o_in_ready  = ~w_stall;
  assign o_x0        = r_x[0*bw +: bw];
  assign o_x1        = r_x[1*bw +: bw];
  assign o_x2        = r_x[2*bw +: bw];
  assign o_x3        = r_x[3*bw +: bw];
  assign o_w0        = r_w[0*bw +: bw];
  assign o_w1        = r_w[1*bw +: bw];
  assign o_w2        = r_w[2*bw +: bw];
  assign o_w3        = r_w[3*bw +: bw];
  assign o_psum_in   = r_acc;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_count = r_out_count;

  // w_commit_last is folded into the result update above; kept named for readability.
  logic w_unused;
  assign w_unused = w_commit_last;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench for mac_dot_seq with a behavioural 4-lane MAC closing the loop.
module tb_mac_dot_seq;

  logic        clk;
  logic        reset_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [15:0] i_x_in;
  logic [15:0] i_w_in;
  logic        i_in_last;
  logic [3:0]  o_x0, o_x1, o_x2, o_x3, o_w0, o_w1, o_w2, o_w3;
  logic [15:0] o_psum_in;
  logic [15:0] w_mac_out;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [15:0] o_out_data;
  logic [9:0]  o_out_count;

  int checks;
  int failures;
  logic [25:0] exp_q[$];

  mac_dot_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_x_in     (i_x_in),
    .i_w_in     (i_w_in),
    .i_in_last  (i_in_last),
    .o_x0       (o_x0),
    .o_x1       (o_x1),
    .o_x2       (o_x2),
    .o_x3       (o_x3),
    .o_w0       (o_w0),
    .o_w1       (o_w1),
    .o_w2       (o_w2),
    .o_w3       (o_w3),
    .o_psum_in  (o_psum_in),
    .i_mac_out  (w_mac_out),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_data (o_out_data),
    .o_out_count(o_out_count)
  );

  assign w_mac_out = 16'(o_x0) * 16'(o_w0) + 16'(o_x1) * 16'(o_w1)
                   + 16'(o_x2) * 16'(o_w2) + 16'(o_x3) * 16'(o_w3) + o_psum_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one pop per completed result handshake.
  always @(negedge clk) begin
    if (reset_n && o_out_valid && i_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got data=%0d count=%0d expected none",
                 o_out_data, o_out_count);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        check("result_data", 32'(o_out_data), 32'(e[25:10]));
        check("result_count", 32'(o_out_count), 32'(e[9:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] w, input logic last);
    int n;
    n = 0;
    i_in_valid = 1'b1;
    i_x_in     = x;
    i_w_in     = w;
    i_in_last  = last;
    while (!o_in_ready && n < 50) begin
      step();
      n++;
    end
    if (!o_in_ready) check("accept_timeout", 32'(o_in_ready), 32'd1);
    step();
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
  endtask

  initial begin
    int n;
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    i_in_valid  = 1'b0;
    i_x_in      = '0;
    i_w_in      = '0;
    i_in_last   = 1'b0;
    i_out_ready = 1'b1;
    #12;
    check("reset_in_ready", 32'(o_in_ready), 32'd1);
    check("reset_out_valid", 32'(o_out_valid), 32'd0);
    check("reset_psum", 32'(o_psum_in), 32'd0);
    check("reset_lanes", 32'({o_x0, o_x1, o_x2, o_x3, o_w0, o_w1, o_w2, o_w3}), 32'd0);
    reset_n = 1'b1;
    step();

    // Single chunk: 1+2+3+4.
    exp_q.push_back({16'd10, 10'd1});
    send(16'h4321, 16'h1111, 1'b1);
    check("single_valid_pre", 32'(o_out_valid), 32'd0);
    step();
    check("single_valid", 32'(o_out_valid), 32'd1);
    step();
    check("single_valid_one_cycle", 32'(o_out_valid), 32'd0);

    // Three back-to-back chunks of 24.
    exp_q.push_back({16'd72, 10'd3});
    send(16'h2222, 16'h3333, 1'b0);
    check("b2b_psum0", 32'(o_psum_in), 32'd0);
    check("b2b_ready0", 32'(o_in_ready), 32'd1);
    send(16'h2222, 16'h3333, 1'b0);
    check("b2b_psum1", 32'(o_psum_in), 32'd24);
    check("b2b_ready1", 32'(o_in_ready), 32'd1);
    send(16'h2222, 16'h3333, 1'b1);
    check("b2b_psum2", 32'(o_psum_in), 32'd48);
    check("b2b_ready2", 32'(o_in_ready), 32'd1);
    repeat (3) step();

    // Backpressure: two single-chunk results with the consumer stalled.
    i_out_ready = 1'b0;
    exp_q.push_back({16'd10, 10'd1});
    exp_q.push_back({16'd8, 10'd1});
    send(16'h4321, 16'h1111, 1'b1);
    send(16'h1111, 16'h2222, 1'b1);
    check("bp_ready_low", 32'(o_in_ready), 32'd0);
    check("bp_valid", 32'(o_out_valid), 32'd1);
    repeat (3) step();
    check("bp_hold_data", 32'(o_out_data), 32'd10);
    check("bp_hold_count", 32'(o_out_count), 32'd1);
    check("bp_still_stalled", 32'(o_in_ready), 32'd0);
    i_out_ready = 1'b1;
    repeat (4) step();
    check("bp_drained", 32'(o_out_valid), 32'd0);

    // Wrap-around: 335 * 196 = 65660 -> 124.
    exp_q.push_back({16'd124, 10'd335});
    for (int i = 0; i < 335; i++) send(16'h7777, 16'h7777, (i == 334));
    repeat (3) step();

    // Reset mid-vector discards the partial sum.
    send(16'h2222, 16'h3333, 1'b0);
    send(16'h2222, 16'h3333, 1'b0);
    check("midrst_psum_pre", 32'(o_psum_in), 32'd24);
    reset_n = 1'b0;
    #1;
    check("midrst_psum", 32'(o_psum_in), 32'd0);
    check("midrst_lanes", 32'({o_x0, o_x1, o_x2, o_x3, o_w0, o_w1, o_w2, o_w3}), 32'd0);
    check("midrst_valid", 32'(o_out_valid), 32'd0);
    check("midrst_data", 32'({o_out_data, o_out_count}), 32'd0);
    check("midrst_ready", 32'(o_in_ready), 32'd1);
    step();
    reset_n = 1'b1;
    step();
    check("postrst_ready", 32'(o_in_ready), 32'd1);
    exp_q.push_back({16'd10, 10'd1});
    send(16'h4321, 16'h1111, 1'b1);
    repeat (3) step();

    // Gapped vector: accumulator holds across idle cycles.
    exp_q.push_back({16'd72, 10'd3});
    send(16'h2222, 16'h3333, 1'b0);
    repeat (2) step();
    check("gap_psum1", 32'(o_psum_in), 32'd24);
    send(16'h2222, 16'h3333, 1'b0);
    step();
    check("gap_psum2a", 32'(o_psum_in), 32'd48);
    step();
    check("gap_psum2b", 32'(o_psum_in), 32'd48);
    send(16'h2222, 16'h3333, 1'b1);
    check("gap_psum3", 32'(o_psum_in), 32'd48);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) check("results_outstanding", 32'(exp_q.size()), 32'd0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Sequencing and accumulation stage wrapped around the 4-lane `mac_wrapper` datapath. It accepts a dot-product vector as a stream of 4-element chunks (x, w) over a valid/ready handshake and registers each chunk onto the MAC's `x0..x3` / `w0..w3` inputs. It feeds its own running accumulator back into `psum_in` and captures `out`, so a vector of any length reduces to one partial sum. The final sum is presented on a valid/ready result port.

## Interface
- `bw`, 4, activation/weight element width (matches `mac_wrapper`)
- `psum_bw`, 16, partial-sum width (matches `mac_wrapper`)
- `len_bw`, 10, width of the chunk counter and `out_count`

- `clk`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  chunk on `x_in`/`w_in`/`in_last` is valid
- `in_ready`  out  1  block accepts the chunk this cycle
- `x_in`  in  4*bw  packed activations; lane k = bits [k*bw +: bw]
- `w_in`  in  4*bw  packed weights, same lane packing
- `in_last`  in  1  chunk is the final chunk of the vector
- `x0..x3`, `w0..w3`  out  bw each  registered lane operands to `mac_wrapper`
- `psum_in`  out  psum_bw  accumulator value to `mac_wrapper`
- `mac_out`  in  psum_bw  `mac_wrapper.out` = Σ xk*wk + `psum_in` (combinational)
- `out_valid`  out  1  result held on `out_data`/`out_count`
- `out_ready`  in  1  consumer takes the result
- `out_data`  out  psum_bw  completed dot product
- `out_count`  out  len_bw  number of chunks in that vector

## Operation
- State: stage register (`s_valid`, `s_last`, lane operands), accumulator `acc`, chunk counter `cnt`, and a result register (`out_valid`, `out_data`, `out_count`).
- `psum_in` = `acc`. The lane outputs are the stage register contents.
- Accept: `in_valid & in_ready`. The chunk loads into the stage register with `s_valid`=1 and `s_last`=`in_last`.
- Stall: `stall = s_valid & s_last & out_valid & ~out_ready`.
- `in_ready = ~stall`, combinational.
- Commit on each edge where `s_valid & ~stall`:
  - Not last: `acc <= mac_out`; `cnt <= cnt+1`.
  - Last: `out_data <= mac_out`; `out_count <= cnt+1`; `out_valid <= 1`; `acc <= 0`; `cnt <= 0`.
- Stage update when not stalled: the stage loads the accepted chunk, or clears `s_valid` if nothing is accepted.
- Stage update when stalled: the stage, `acc` and `cnt` all hold.
- Result handshake: `out_valid & out_ready` with no simultaneous last-commit clears `out_valid`. A simultaneous last-commit overwrites the result and keeps `out_valid`=1.
- Arithmetic: `acc` and `out_data` wrap modulo 2^psum_bw with no saturation. `cnt` wraps modulo 2^len_bw. Signedness is whatever `mac_wrapper` implements; this block only moves bits.
- `in_valid` gaps inside a vector are allowed. The accumulator holds across idle cycles.
- Reset (`reset_n` low, any time including mid-vector):
  - All registers go to 0: lanes, `psum_in`, `acc`, `cnt`, `s_valid`, `out_valid`, `out_data`, `out_count`.
  - `in_ready` = 1 while in reset and after release.
  - A partial vector is discarded.

## Timing
- Throughput: one chunk per cycle when not stalled.
- Latency: if the last chunk is accepted at edge t, `out_valid`=1 after edge t+1.
- Result hold: `out_data` and `out_count` are stable while `out_valid` & ~`out_ready`.
- Backpressure: at most one completed result plus one staged last chunk are buffered. Non-last chunks keep streaming while a result is pending.
- Same-cycle behaviour: the block accepts a chunk in the same cycle that it commits the previous last chunk. The new vector starts from `acc`=0.

## Test plan
- Single chunk: x=(1,2,3,4), w=(1,1,1,1), `in_last`=1, `out_ready`=1 → `out_data`=10 and `out_count`=1, with `out_valid` asserted for one cycle two edges after accept.
- Back-to-back three-chunk vector: all x=2, w=3 → `psum_in` steps 0, 24, 48; result 72, `out_count`=3; `in_ready` stays 1.
- Backpressure: two consecutive single-chunk vectors (10, then x=(1,1,1,1)·w=(2,2,2,2)=8) with `out_ready`=0 → first result 10 held, then `in_ready`=0. Raising `out_ready` yields 10 then 8 with nothing lost or duplicated.
- Wrap-around: 335 chunks of x=7, w=7 (196 each) → `out_data`=124 (65660 mod 65536), `out_count`=335.
- Reset mid-vector: two non-last chunks, then `reset_n` pulsed low → all outputs 0 and `in_ready`=1. A following single chunk summing to 10 returns 10 with count 1.
- Gapped input: three-chunk 72 vector from the second scenario, with 2 idle cycles between each chunk → 72, count 3; `psum_in` held during the gaps.
